// File: rtl/circular_line_buffer.sv
// Circular line buffer between the input feeder and the PE array: PAR_WRITE elements in per
// write handshake, one element out per read handshake, first-word-fall-through ordering.
module circular_line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int PAR_WRITE  = 1,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] wr_data,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [CNT_W-1:0]                count,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_full
);

  localparam int SUM_W = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wp;
  logic [ADDR_W-1:0]     rp;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        count_ext;
  logic [CNT_W:0]        free_ext;
  logic [CNT_W:0]        count_next;
  logic                  cnt_msb_unused;

  // DEPTH need not be a power of two, so wrap by compare/subtract rather than truncation.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] ptr, input int inc);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, ptr} + SUM_W'(inc);
    if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
    return sum[ADDR_W-1:0];
  endfunction

  assign count_ext = {1'b0, count};
  assign free_ext  = (CNT_W+1)'(DEPTH) - count_ext;

  // Status depends on registered count only: no path from rd_ready/wr_valid to wr_ready.
  assign wr_ready    = (free_ext >= (CNT_W+1)'(PAR_WRITE));
  assign rd_valid    = (count != '0);
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count_ext >= (CNT_W+1)'(AF_LEVEL));
  assign rd_data     = rd_valid ? mem[rp] : '0;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;

  assign count_next = count_ext
                    + (push ? (CNT_W+1)'(PAR_WRITE) : '0)
                    - (pop  ? (CNT_W+1)'(1)         : '0);
  assign cnt_msb_unused = count_next[CNT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wrap_add(wp, PAR_WRITE);
      if (pop)  rp <= wrap_add(rp, 1);
      count <= count_next[CNT_W-1:0];
    end
  end

  // wr_ready guarantees the written slots never include rp while data is stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (push && !flush) begin
      for (int i = 0; i < PAR_WRITE; i++)
        mem[wrap_add(wp, i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_circular_line_buffer.sv
// Directed bench for circular_line_buffer: three instances cover DEPTH=8/PAR_WRITE=2,
// DEPTH=6/PAR_WRITE=4 and DEPTH=8/PAR_WRITE=1/AF_LEVEL=6.
module tb_circular_line_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A: DEPTH=8, PAR_WRITE=2
  logic        a_flush = 1'b0, a_wr_valid = 1'b0, a_rd_ready = 1'b0;
  logic [31:0] a_wr_data = '0;
  logic        a_wr_ready, a_rd_valid, a_empty, a_full, a_af;
  logic [15:0] a_rd_data;
  logic [3:0]  a_count;

  // Instance B: DEPTH=6, PAR_WRITE=4
  logic        b_flush = 1'b0, b_wr_valid = 1'b0, b_rd_ready = 1'b0;
  logic [63:0] b_wr_data = '0;
  logic        b_wr_ready, b_rd_valid, b_empty, b_full, b_af;
  logic [15:0] b_rd_data;
  logic [2:0]  b_count;

  // Instance C: DEPTH=8, PAR_WRITE=1, AF_LEVEL=6
  logic        c_flush = 1'b0, c_wr_valid = 1'b0, c_rd_ready = 1'b0;
  logic [15:0] c_wr_data = '0;
  logic        c_wr_ready, c_rd_valid, c_empty, c_full, c_af;
  logic [15:0] c_rd_data;
  logic [3:0]  c_count;

  circular_line_buffer #(.DATA_WIDTH(16), .DEPTH(8), .PAR_WRITE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
    .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
    .count(a_count), .empty(a_empty), .full(a_full), .almost_full(a_af)
  );

  circular_line_buffer #(.DATA_WIDTH(16), .DEPTH(6), .PAR_WRITE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
    .count(b_count), .empty(b_empty), .full(b_full), .almost_full(b_af)
  );

  circular_line_buffer #(.DATA_WIDTH(16), .DEPTH(8), .PAR_WRITE(1), .AF_LEVEL(6)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush),
    .wr_valid(c_wr_valid), .wr_ready(c_wr_ready), .wr_data(c_wr_data),
    .rd_valid(c_rd_valid), .rd_ready(c_rd_ready), .rd_data(c_rd_data),
    .count(c_count), .empty(c_empty), .full(c_full), .almost_full(c_af)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, checked while rst_n is low before any clock edge
    #3;
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_a_empty", 32'(a_empty), 1);
    chk("rst_a_full", 32'(a_full), 0);
    chk("rst_a_rd_valid", 32'(a_rd_valid), 0);
    chk("rst_a_wr_ready", 32'(a_wr_ready), 1);
    chk("rst_a_rd_data", 32'(a_rd_data), 0);
    chk("rst_b_wr_ready", 32'(b_wr_ready), 1);
    chk("rst_c_af", 32'(c_af), 0);
    step();
    rst_n = 1'b1;

    // Fill A with four double-element pushes
    for (int k = 0; k < 4; k++) begin
      a_wr_data  = {16'(2*k + 1), 16'(2*k)};
      a_wr_valid = 1'b1;
      step();
    end
    chk("fill_count", 32'(a_count), 8);
    chk("fill_full", 32'(a_full), 1);
    chk("fill_wr_ready", 32'(a_wr_ready), 0);
    chk("fill_af", 32'(a_af), 1);
    chk("fill_head", 32'(a_rd_data), 32'h00);
    a_wr_data = {16'h00AA, 16'h00BB};
    step();
    chk("push_full_count", 32'(a_count), 8);
    chk("push_full_head", 32'(a_rd_data), 32'h00);
    a_wr_valid = 1'b0;

    // Drain A in order
    a_rd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 32'(a_rd_valid), 1);
      chk("drain_data", 32'(a_rd_data), 32'(k));
      step();
    end
    a_rd_ready = 1'b0;
    chk("drain_empty", 32'(a_empty), 1);
    chk("drain_count", 32'(a_count), 0);
    chk("drain_rd_data", 32'(a_rd_data), 0);
    a_rd_ready = 1'b1;
    step();
    chk("pop_empty_count", 32'(a_count), 0);
    a_rd_ready = 1'b0;

    // Simultaneous push/pop at count=6
    for (int k = 0; k < 3; k++) begin
      a_wr_data  = {16'(16'h21 + 2*k), 16'(16'h20 + 2*k)};
      a_wr_valid = 1'b1;
      step();
    end
    a_wr_valid = 1'b0;
    chk("pp_pre_count", 32'(a_count), 6);
    chk("pp_pre_wr_ready", 32'(a_wr_ready), 1);
    chk("pp_head", 32'(a_rd_data), 32'h20);
    a_wr_data  = {16'h0027, 16'h0026};
    a_wr_valid = 1'b1;
    a_rd_ready = 1'b1;
    step();
    a_wr_valid = 1'b0;
    chk("pp_count", 32'(a_count), 7);
    chk("pp_wr_ready", 32'(a_wr_ready), 0);
    chk("pp_next_head", 32'(a_rd_data), 32'h21);
    step();
    chk("pop_count", 32'(a_count), 6);
    chk("pop_wr_ready", 32'(a_wr_ready), 1);
    chk("pop_head", 32'(a_rd_data), 32'h22);
    step();
    a_rd_ready = 1'b0;
    chk("pre_flush_count", 32'(a_count), 5);
    chk("pre_flush_head", 32'(a_rd_data), 32'h23);

    // Flush wins over a concurrent push and pop
    a_flush    = 1'b1;
    a_wr_valid = 1'b1;
    a_rd_ready = 1'b1;
    a_wr_data  = {16'h0099, 16'h0098};
    step();
    a_flush    = 1'b0;
    a_wr_valid = 1'b0;
    a_rd_ready = 1'b0;
    chk("flush_count", 32'(a_count), 0);
    chk("flush_empty", 32'(a_empty), 1);
    chk("flush_rd_data", 32'(a_rd_data), 0);
    step();
    chk("flush_hold_count", 32'(a_count), 0);
    a_wr_data  = {16'h0031, 16'h0030};
    a_wr_valid = 1'b1;
    step();
    a_wr_valid = 1'b0;
    chk("post_flush_count", 32'(a_count), 2);
    chk("post_flush_head", 32'(a_rd_data), 32'h30);

    // B: wrap in a six-deep buffer
    b_wr_data  = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    b_wr_valid = 1'b1;
    step();
    b_wr_valid = 1'b0;
    chk("wrap_count4", 32'(b_count), 4);
    chk("wrap_wr_ready4", 32'(b_wr_ready), 0);
    b_rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("wrap_pop_data", 32'(b_rd_data), 32'(16'h10 + k));
      step();
    end
    b_rd_ready = 1'b0;
    chk("wrap_count1", 32'(b_count), 1);
    chk("wrap_wr_ready1", 32'(b_wr_ready), 1);
    b_wr_data  = {16'h0017, 16'h0016, 16'h0015, 16'h0014};
    b_wr_valid = 1'b1;
    step();
    b_wr_valid = 1'b0;
    chk("wrap_count5", 32'(b_count), 5);
    chk("wrap_wr_ready5", 32'(b_wr_ready), 0);
    b_rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("wrap_read_data", 32'(b_rd_data), 32'(16'h13 + k));
      step();
    end
    b_rd_ready = 1'b0;
    chk("wrap_empty", 32'(b_empty), 1);

    // C: almost-full at AF_LEVEL=6
    c_wr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      c_wr_data = 16'(16'h40 + k);
      step();
    end
    chk("af_at5", 32'(c_af), 0);
    c_wr_data = 16'h0045;
    step();
    chk("af_at6", 32'(c_af), 1);
    chk("af_count6", 32'(c_count), 6);
    chk("af_head", 32'(c_rd_data), 32'h40);

    // Reset dropped mid-cycle while a push is pending
    c_wr_data = 16'h0046;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(c_count), 0);
    chk("mid_rst_af", 32'(c_af), 0);
    chk("mid_rst_empty", 32'(c_empty), 1);
    chk("mid_rst_rd_data", 32'(c_rd_data), 0);
    step();
    chk("rst_hold_count", 32'(c_count), 0);
    c_wr_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_count", 32'(c_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
